// File: rtl/uart_rx_framed_if.sv
`default_nettype none
// ============================================================
// uart_rx_framed_if : receive-stream handshake between the UART
//                     receiver FIFO head and its consumer
// Revision: 1.0
// ============================================================
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================
// uart_rx_framed : UART receiver with parity/stop checking and a
//                  first-word fall-through receive FIFO
// Revision: 1.0
// ============================================================
module uart_rx_framed #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire              sys_clk,
    input  wire              sys_rst,
    input  wire              uart_rxd,
    uart_rx_framed_if.master rx,
    output logic             overrun,
    output logic             busy
);
    localparam int BAUD_CNT = CLK_FREQ / BAUD;
    localparam int HALF     = BAUD_CNT / 2;
    localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam int IDX_W    = $clog2(DATA_BITS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int WORD_W   = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic                 rxd_meta;
    logic                 rxd_s;
    logic                 rxd_prev;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;
    logic                 par_bad;
    logic                 wr_valid;
    logic [WORD_W-1:0]    wr_word;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    // Parity verdict for the bit currently on the line against the shifted data
    generate
        if (PARITY == 0) begin : g_no_parity
            assign par_bad = 1'b0;
        end else if (PARITY == 1) begin : g_odd_parity
            assign par_bad = ~(^shreg ^ rxd_s);
        end else begin : g_even_parity
            assign par_bad = ^shreg ^ rxd_s;
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            wr_valid <= 1'b0;
            wr_word  <= '0;
        end else begin
            wr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rxd_prev && !rxd_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                            stop_idx <= 1'b0;
                            state    <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        perr  <= par_bad;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        // Hand the frame off at the last stop sample, not at bit end
                        if (stop_idx == LAST_STOP) begin
                            wr_valid <= 1'b1;
                            wr_word  <= {shreg, perr, ferr | ~rxd_s};
                            state    <= IDLE;
                        end else begin
                            ferr     <= ferr | ~rxd_s;
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic [WORD_W-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && rx.rx_ready;
    assign push  = wr_valid && (!full || pop);

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= wr_valid && full && !pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign rx.rx_valid   = !empty;
    assign rx.rx_data    = empty ? '0 : head[WORD_W-1:2];
    assign rx.parity_err = empty ? 1'b0 : head[1];
    assign rx.frame_err  = empty ? 1'b0 : head[0];
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// ============================================================
// tb_uart_rx_framed : randomized bench for uart_rx_framed (8N1 and
//                     7E2 instances) against a frame-level model
// Revision: 1.0
// ============================================================
module tb_uart_rx_framed;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BC       = CLK_FREQ / BAUD;
    localparam int HALF     = BC / 2;
    localparam int DEPTH    = 4;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } entry_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd_a = 1'b1;
    logic rxd_b = 1'b1;
    logic ovr_a, busy_a, ovr_b, busy_b;

    uart_rx_framed_if #(.DATA_BITS(8)) if_a ();
    uart_rx_framed_if #(.DATA_BITS(7)) if_b ();

    uart_rx_framed #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .sys_clk(clk), .sys_rst(rst_n), .uart_rxd(rxd_a),
        .rx(if_a.master), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_framed #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
        .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .sys_clk(clk), .sys_rst(rst_n), .uart_rxd(rxd_b),
        .rx(if_b.master), .overrun(ovr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_b = 0;
    int val_cnt_a = 0;
    logic [9:0] last_a = '0;
    entry_t q_a[$];
    entry_t q_b[$];

    always @(negedge clk) begin
        if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
        if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
        if (if_a.rx_valid) begin
            val_cnt_a <= val_cnt_a + 1;
            last_a    <= {if_a.rx_data, if_a.parity_err, if_a.frame_err};
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish, time=%0t required finish", $time);
        $fatal(1);
    end

    // Frame-level model: serial bit list plus the entry the receiver should store
    function automatic void make_frame(input int which, input logic [8:0] d,
                                       input logic pflip, input logic sbad,
                                       output logic [15:0] bits, output int n,
                                       output entry_t e);
        int   db   = (which == 0) ? 8 : 7;
        int   pm   = (which == 0) ? 0 : 2;
        int   ns   = (which == 0) ? 1 : 2;
        int   ones = 0;
        logic p    = 1'b0;
        bits = '1;
        n    = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < db; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pm != 0) begin
            p = (pm == 2) ? logic'(ones % 2) : logic'(ones % 2 == 0);
            p = p ^ pflip;
            bits[n] = p; n++;
        end
        for (int i = 0; i < ns; i++) begin
            bits[n] = ~sbad; n++;
        end
        e.d  = (which == 0) ? {1'b0, d[7:0]} : {2'b00, d[6:0]};
        e.pe = (pm == 0) ? 1'b0 :
               (pm == 2) ? logic'((ones + int'(p)) % 2 == 1) :
                           logic'((ones + int'(p)) % 2 == 0);
        e.fe = sbad;
    endfunction

    task automatic drive_line(input int which, input logic v);
        if (which == 0) rxd_a = v; else rxd_b = v;
    endtask

    task automatic send_frame(input int which, input logic [15:0] bits, input int n,
                              input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_line(which, bits[i]);
            repeat (BC - 1) @(negedge clk);
        end
        if (gap > 0) begin
            @(negedge clk);
            drive_line(which, 1'b1);
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic queue_and_send(input int which, input logic [8:0] d, input logic pflip,
                                  input logic sbad, input int gap);
        logic [15:0] bits;
        int          n;
        entry_t      e;
        make_frame(which, d, pflip, sbad, bits, n, e);
        if (which == 0) begin
            if (q_a.size() < DEPTH) q_a.push_back(e);
        end else begin
            if (q_b.size() < DEPTH) q_b.push_back(e);
        end
        send_frame(which, bits, n, gap);
    endtask

    task automatic drain(input int which, input string tag);
        entry_t     e;
        logic       v, pe, fe;
        logic [8:0] d;
        int         n = (which == 0) ? q_a.size() : q_b.size();
        for (int k = 0; k < n; k++) begin
            if (which == 0) e = q_a.pop_front(); else e = q_b.pop_front();
            @(negedge clk);
            v  = (which == 0) ? if_a.rx_valid : if_b.rx_valid;
            d  = (which == 0) ? {1'b0, if_a.rx_data} : {2'b00, if_b.rx_data};
            pe = (which == 0) ? if_a.parity_err : if_b.parity_err;
            fe = (which == 0) ? if_a.frame_err : if_b.frame_err;
            vectors++;
            if (v !== 1'b1) begin
                errors++;
                $display("FAIL %s valid[%0d]: got %b expected 1", tag, k, v);
            end
            vectors++;
            if (d !== e.d || pe !== e.pe || fe !== e.fe) begin
                errors++;
                $display("FAIL %s entry[%0d]: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b",
                         tag, k, d, pe, fe, e.d, e.pe, e.fe);
            end
            if (which == 0) if_a.rx_ready = 1'b1; else if_b.rx_ready = 1'b1;
            @(negedge clk);
            if (which == 0) if_a.rx_ready = 1'b0; else if_b.rx_ready = 1'b0;
        end
        @(negedge clk);
        v = (which == 0) ? if_a.rx_valid : if_b.rx_valid;
        d = (which == 0) ? {1'b0, if_a.rx_data} : {2'b00, if_b.rx_data};
        vectors++;
        if (v !== 1'b0 || d !== 9'd0) begin
            errors++;
            $display("FAIL %s empty: got valid=%b data=%h expected valid=0 data=0", tag, v, d);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({if_a.rx_valid, if_a.rx_data, if_a.parity_err, if_a.frame_err, ovr_a, busy_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_a: got v=%b d=%h pe=%b fe=%b ovr=%b busy=%b expected all 0",
                     if_a.rx_valid, if_a.rx_data, if_a.parity_err, if_a.frame_err, ovr_a, busy_a);
        end
        vectors++;
        if ({if_b.rx_valid, if_b.rx_data, if_b.parity_err, if_b.frame_err, ovr_b, busy_b} !== 12'd0) begin
            errors++;
            $display("FAIL reset_b: got v=%b d=%h busy=%b expected all 0",
                     if_b.rx_valid, if_b.rx_data, busy_b);
        end
        rst_n = 1'b1;
        repeat (BC) @(negedge clk);
    endtask

    task automatic test_single_pulse;
        int   v0 = val_cnt_a;
        logic [15:0] bits;
        int   n;
        entry_t e;
        if_a.rx_ready = 1'b1;
        make_frame(0, 9'h055, 1'b0, 1'b0, bits, n, e);
        send_frame(0, bits, n, 2 * BC);
        if_a.rx_ready = 1'b0;
        vectors++;
        if (val_cnt_a - v0 != 1) begin
            errors++;
            $display("FAIL single_pulse_width: got %0d cycles expected 1", val_cnt_a - v0);
        end
        vectors++;
        if (last_a !== {e.d[7:0], e.pe, e.fe}) begin
            errors++;
            $display("FAIL single_pulse_data: got %h expected %h", last_a, {e.d[7:0], e.pe, e.fe});
        end
    endtask

    task automatic test_parity;
        queue_and_send(1, 9'h041, 1'b1, 1'b0, 2 * BC);
        queue_and_send(1, 9'h041, 1'b0, 1'b0, 2 * BC);
        drain(1, "parity");
    endtask

    task automatic test_frame_err;
        queue_and_send(0, 9'h0A3, 1'b0, 1'b1, BC);
        queue_and_send(0, 9'h00F, 1'b0, 1'b0, 2 * BC);
        drain(0, "frame_err");
    endtask

    task automatic test_glitch;
        int hi = 0;
        int v0 = val_cnt_a;
        for (int i = 0; i < 4 * BC; i++) begin
            @(negedge clk);
            if (busy_a) hi++;
            rxd_a = (i < BC / 4) ? 1'b0 : 1'b1;
        end
        vectors++;
        if (hi != HALF) begin
            errors++;
            $display("FAIL glitch_busy: got %0d cycles expected %0d", hi, HALF);
        end
        vectors++;
        if (val_cnt_a != v0 || if_a.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_write: got %0d valid cycles expected 0", val_cnt_a - v0);
        end
    endtask

    task automatic test_overrun;
        int o0 = ovr_cnt_a;
        for (int i = 1; i <= 5; i++) begin
            queue_and_send(0, 9'(i), 1'b0, 1'b0, (i == 5) ? 2 * BC : 0);
        end
        vectors++;
        if (ovr_cnt_a - o0 != 1) begin
            errors++;
            $display("FAIL overrun_count: got %0d expected 1", ovr_cnt_a - o0);
        end
        drain(0, "overrun");
    endtask

    task automatic test_reset_midframe;
        logic [15:0] bits;
        int          n;
        entry_t      e;
        queue_and_send(0, 9'h03C, 1'b0, 1'b0, 2 * BC);
        make_frame(0, 9'h0C6, 1'b0, 1'b0, bits, n, e);
        send_frame(0, bits, 4, 0);
        @(negedge clk);
        rxd_a = bits[4];
        repeat (HALF) @(negedge clk);
        vectors++;
        if (busy_a !== 1'b1 || if_a.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre: got busy=%b valid=%b expected 1 1", busy_a, if_a.rx_valid);
        end
        rst_n = 1'b0;
        rxd_a = 1'b1;
        @(negedge clk);
        vectors++;
        if ({if_a.rx_valid, if_a.rx_data, if_a.parity_err, if_a.frame_err, ovr_a, busy_a} !== 13'd0) begin
            errors++;
            $display("FAIL midframe_reset: got v=%b d=%h busy=%b expected all 0",
                     if_a.rx_valid, if_a.rx_data, busy_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q_a.delete();
        q_b.delete();
        repeat (BC) @(negedge clk);
        queue_and_send(0, 9'h0C6, 1'b0, 1'b0, 2 * BC);
        drain(0, "midframe");
    endtask

    task automatic test_random;
        for (int r = 0; r < 10; r++) begin
            int which = int'($urandom_range(0, 1));
            int k     = int'($urandom_range(1, 6));
            int o0    = (which == 0) ? ovr_cnt_a : ovr_cnt_b;
            int exp_o = 0;
            int o1;
            for (int j = 0; j < k; j++) begin
                logic [8:0] d     = 9'($urandom);
                logic       pflip = (which == 1) ? logic'($urandom_range(0, 1)) : 1'b0;
                logic       sbad  = ($urandom_range(0, 3) == 0);
                if (((which == 0) ? q_a.size() : q_b.size()) >= DEPTH) exp_o++;
                queue_and_send(which, d, pflip, sbad, 4);
            end
            repeat (2 * BC) @(negedge clk);
            o1 = (which == 0) ? ovr_cnt_a : ovr_cnt_b;
            vectors++;
            if (o1 - o0 != exp_o) begin
                errors++;
                $display("FAIL random_overrun[%0d]: got %0d expected %0d", r, o1 - o0, exp_o);
            end
            drain(which, "random");
        end
    endtask

    initial begin
        if_a.rx_ready = 1'b0;
        if_b.rx_ready = 1'b0;
        test_reset();
        test_single_pulse();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate; BAUD_CNT = CLK_FREQ/BAUD (integer), HALF = BAUD_CNT/2.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 Parameter PARITY, default 0, 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 4, receive FIFO entries, power of 2, minimum 2.
REQ-007 sys_clk  in  1  system clock, all logic on rising edge.
REQ-008 sys_rst  in  1  reset, asynchronous, active-low.
REQ-009 uart_rxd  in  1  asynchronous serial input, idle high.
REQ-010 rx_data  out  DATA_BITS  FIFO head data, LSB = first received bit.
REQ-011 rx_valid  out  1  FIFO non-empty, head valid.
REQ-012 rx_ready  in  1  consumer accepts head when rx_valid and rx_ready are both 1.
REQ-013 parity_err  out  1  head entry's parity flag, meaningful only when rx_valid = 1.
REQ-014 frame_err  out  1  head entry's stop-bit flag, meaningful only when rx_valid = 1.
REQ-015 overrun  out  1  one-cycle pulse when a completed frame is dropped.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 uart_rxd SHALL pass a 2-flop synchronizer (both flops reset to 1); all sampling uses the second flop.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; one baud counter, cleared on every state entry.
REQ-019 IDLE: a synchronized 1->0 transition SHALL move to START with the counter at 0.
REQ-020 START: at count HALF-1, line low -> DATA; line high -> IDLE with no FIFO write (false start).
REQ-021 DATA: each bit sampled at count BAUD_CNT-1, LSB first; after DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
REQ-022 PARITY: one bit sampled at BAUD_CNT-1; parity_err = 1 when the XOR of data and parity bit is 0 for odd, or 1 for even; PARITY = 0 forces the flag to 0.
REQ-023 STOP: STOP_BITS bits, each sampled at BAUD_CNT-1; frame_err = 1 if any stop sample is 0.
REQ-024 The last stop sample SHALL write {data, parity_err, frame_err} to the FIFO on the next cycle and return to IDLE in the same cycle, with no wait for the end of the stop bit.
REQ-025 A frame with an error SHALL still be written, with its flag set.
REQ-026 The FIFO SHALL be first-word fall-through: rx_valid rises the cycle after the write into an empty FIFO; rx_data and the flags equal the head entry.
REQ-027 A pop SHALL occur only on rx_valid and rx_ready; rx_ready with rx_valid = 0 has no effect.
REQ-028 FIFO full at write time with no pop that cycle: drop the frame, pulse overrun for 1 cycle, leave contents unchanged.
REQ-029 FIFO full with a pop in the same cycle: accept the write (pop first), no overrun.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit or an occupancy counter of clog2(FIFO_DEPTH)+1 bits.
REQ-031 When rx_valid = 0, rx_data, parity_err and frame_err SHALL be 0.
REQ-032 Line activity in STOP or DATA SHALL NOT restart the FSM; start detection happens only in IDLE.

Reset
REQ-033 Reset SHALL force: FSM to IDLE, counters and FIFO empty, rx_valid/rx_data/parity_err/frame_err/overrun/busy to 0, synchronizer flops to 1.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release the FSM waits for a fresh 1->0 edge.

Verification
REQ-035 Defaults, 8N1 frame 0x55 with rx_ready = 1 -> rx_valid for exactly 1 cycle, rx_data = 0x55, both error flags 0.
REQ-036 PARITY = 2, DATA_BITS = 7, frame 0x41 with parity bit 1 (wrong) -> rx_data = 0x41, parity_err = 1; with parity bit 0 -> parity_err = 0.
REQ-037 Stop bit driven 0 for frame 0xA3 -> rx_data = 0xA3, frame_err = 1; the next correct frame 0x0F is received clean.
REQ-038 Low glitch of BAUD_CNT/4 cycles on an idle line -> busy returns to 0 after HALF cycles, no FIFO write.
REQ-039 rx_ready = 0, five frames 0x01..0x05, FIFO_DEPTH = 4 -> overrun pulses once (5th frame); draining yields 0x01..0x04 in order, then rx_valid = 0.
REQ-040 Reset pulsed during bit 3 of a frame -> all outputs 0; the following frame 0xC6 is received correctly.
